// File: rtl/bullet_pkg.sv
// Shared constants and the plotter state encoding for the bullet subsystem.
// The slot count is also used by the bullet pool so both sides agree on pool size.
package bullet_pkg;

  localparam int BULLET_SLOTS  = 160;
  localparam int SLOT_IDX_W    = 8;
  localparam int SCREEN_X_MAX  = 159;
  localparam int SCREEN_Y_MAX  = 119;

  localparam logic [2:0] COLOUR_BG = 3'b000;
  localparam logic [2:0] COLOUR_FG = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } plot_state_e;

endpackage

// File: rtl/bullet_shadow_ram.sv
// Per-slot record of the pixel last drawn: {prev_x, prev_y}.
// Synchronous write, asynchronous read; validity is tracked by the parent.
module bullet_shadow_ram #(
  parameter int NUM_SLOTS = 160,
  parameter int SLOT_W    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SLOT_W-1:0] waddr,
  input  logic [14:0]       wdata,
  input  logic [SLOT_W-1:0] raddr,
  output logic [14:0]       rdata
);

  logic [14:0] mem [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bullet_plotter.sv
// Per-frame scanner: for every slot, erase last frame's pixel, draw the current one,
// and retire bullets that have left the screen. Four cycles per slot, fixed.
module bullet_plotter
  import bullet_pkg::*;
#(
  parameter int          NUM_SLOTS = BULLET_SLOTS,
  parameter int          SLOT_W    = SLOT_IDX_W,
  parameter int          X_MAX     = SCREEN_X_MAX,
  parameter int          Y_MAX     = SCREEN_Y_MAX,
  parameter logic [2:0]  BG_COLOUR = COLOUR_BG,
  parameter logic [2:0]  FG_COLOUR = COLOUR_FG
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_tick,
  output logic [SLOT_W-1:0] slot_sel,
  input  logic              slot_active,
  input  logic [7:0]        slot_x,
  input  logic [6:0]        slot_y,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  output logic              retire,
  output logic [SLOT_W-1:0] retire_slot,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0]        XMAX_L    = 8'(X_MAX);
  localparam logic [6:0]        YMAX_L    = 7'(Y_MAX);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  plot_state_e           state_q, state_d;
  logic [SLOT_W-1:0]     idx_q, idx_d;
  logic [NUM_SLOTS-1:0]  prev_valid_q;
  logic                  cap_act_q;
  logic [7:0]            cap_x_q;
  logic [6:0]            cap_y_q;

  logic                  shadow_we;
  logic                  valid_set, valid_clr;
  logic [14:0]           shadow_rdata;
  logic                  in_bounds;

  bullet_shadow_ram #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_shadow (
    .clk   (clk),
    .we    (shadow_we),
    .waddr (idx_q),
    .wdata ({cap_x_q, cap_y_q}),
    .raddr (idx_q),
    .rdata (shadow_rdata)
  );

  assign in_bounds = (cap_x_q <= XMAX_L) && (cap_y_q <= YMAX_L);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      prev_valid_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (valid_set) begin
        prev_valid_q[idx_q] <= 1'b1;
      end else if (valid_clr) begin
        prev_valid_q[idx_q] <= 1'b0;
      end
    end
  end

  // Pool read data arrives the cycle after slot_sel, i.e. during WAIT.
  always_ff @(posedge clk) begin
    if (state_q == ST_WAIT) begin
      cap_act_q <= slot_active;
      cap_x_q   <= slot_x;
      cap_y_q   <= slot_y;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_we   = 1'b0;
    valid_set   = 1'b0;
    valid_clr   = 1'b0;
    x           = '0;
    y           = '0;
    colour      = '0;
    plot        = 1'b0;
    retire      = 1'b0;
    retire_slot = '0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_ERASE;
      ST_ERASE: begin
        if (prev_valid_q[idx_q]) begin
          plot   = 1'b1;
          x      = shadow_rdata[14:7];
          y      = shadow_rdata[6:0];
          colour = BG_COLOUR;
        end
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (cap_act_q && in_bounds) begin
          plot      = 1'b1;
          x         = cap_x_q;
          y         = cap_y_q;
          colour    = FG_COLOUR;
          shadow_we = 1'b1;
          valid_set = 1'b1;
        end else if (cap_act_q) begin
          retire      = 1'b1;
          retire_slot = idx_q;
          valid_clr   = 1'b1;
        end else begin
          valid_clr = 1'b1;
        end
        if (idx_q == LAST_SLOT) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + SLOT_W'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign slot_sel = idx_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bullet_plotter.sv
// Directed bench for bullet_plotter: a registered pool model feeds slot data and
// each pass's plot/retire/done/busy activity is logged by cycle for checking.
module tb_bullet_plotter;

  logic       clk;
  logic       resetn;
  logic       frame_tick;
  logic [7:0] slot_sel;
  logic       slot_active;
  logic [7:0] slot_x;
  logic [6:0] slot_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       retire;
  logic [7:0] retire_slot;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  bullet_plotter dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .slot_sel    (slot_sel),
    .slot_active (slot_active),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .retire      (retire),
    .retire_slot (retire_slot),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       pa [0:255];
  logic [7:0] px [0:255];
  logic [6:0] py [0:255];

  always @(posedge clk) begin
    slot_active <= pa[slot_sel];
    slot_x      <= px[slot_sel];
    slot_y      <= py[slot_sel];
  end

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_ev_t;

  plot_ev_t pq[$];
  int       rq_cyc[$];
  int       rq_slot[$];
  int       done_q[$];
  int       busy_cnt, busy_first, busy_last;
  logic [37:0] rst_snap;

  function automatic logic [37:0] out_snapshot();
    return {slot_sel, x, y, colour, plot, retire, retire_slot, busy, done};
  endfunction

  task automatic run_pass(input int ncyc, input int tick_at, input int rst_at);
    plot_ev_t ev;
    pq.delete(); rq_cyc.delete(); rq_slot.delete(); done_q.delete();
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    rst_snap = '1;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        resetn = 1'b0;
        #1 rst_snap = out_snapshot();
      end
      if (c == rst_at + 2) resetn = 1'b1;
      if (plot) begin
        ev.cyc = c; ev.x = x; ev.y = y; ev.c = colour;
        pq.push_back(ev);
      end
      if (retire) begin
        rq_cyc.push_back(c);
        rq_slot.push_back(int'(retire_slot));
      end
      if (done) done_q.push_back(c);
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (c == tick_at) frame_tick = 1'b1;
      if (c == tick_at + 1) frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_snapshot() !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", out_snapshot());
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_all_inactive();
    run_pass(660, -10, -10);
    n_checks++;
    if (pq.size() != 0) begin
      n_fail++; $display("FAIL empty_no_plot: got %0d plots want 0", pq.size());
    end
    n_checks++;
    if (busy_cnt != 641 || busy_first != 0 || busy_last != 640) begin
      n_fail++;
      $display("FAIL empty_busy: got cnt %0d first %0d last %0d want 641 0 640",
               busy_cnt, busy_first, busy_last);
    end
    n_checks++;
    if (done_q.size() != 1) begin
      n_fail++; $display("FAIL empty_done_count: got %0d want 1", done_q.size());
    end else begin
      n_checks++;
      if (done_q[0] != 640) begin
        n_fail++; $display("FAIL empty_done_cycle: got %0d want 640", done_q[0]);
      end
    end
  endtask

  task automatic test_first_draw();
    pa[3] = 1'b1; px[3] = 8'd10; py[3] = 7'd20;
    run_pass(645, -10, -10);
    n_checks++;
    if (pq.size() != 1) begin
      n_fail++; $display("FAIL draw_count: got %0d plots want 1", pq.size());
    end else begin
      n_checks++;
      if (pq[0].cyc != 15 || pq[0].x !== 8'd10 || pq[0].y !== 7'd20 || pq[0].c !== 3'd7) begin
        n_fail++;
        $display("FAIL draw_pixel: got cyc %0d (%0d,%0d) col %0d want cyc 15 (10,20) col 7",
                 pq[0].cyc, pq[0].x, pq[0].y, pq[0].c);
      end
    end
    n_checks++;
    if (rq_cyc.size() != 0) begin
      n_fail++; $display("FAIL draw_no_retire: got %0d retires want 0", rq_cyc.size());
    end
  endtask

  task automatic test_erase_redraw();
    px[3] = 8'd11;
    run_pass(645, -10, -10);
    n_checks++;
    if (pq.size() != 2) begin
      n_fail++; $display("FAIL move_count: got %0d plots want 2", pq.size());
    end else begin
      n_checks++;
      if (pq[0].cyc != 14 || pq[0].x !== 8'd10 || pq[0].y !== 7'd20 || pq[0].c !== 3'd0) begin
        n_fail++;
        $display("FAIL move_erase: got cyc %0d (%0d,%0d) col %0d want cyc 14 (10,20) col 0",
                 pq[0].cyc, pq[0].x, pq[0].y, pq[0].c);
      end
      n_checks++;
      if (pq[1].cyc != 15 || pq[1].x !== 8'd11 || pq[1].y !== 7'd20 || pq[1].c !== 3'd7) begin
        n_fail++;
        $display("FAIL move_draw: got cyc %0d (%0d,%0d) col %0d want cyc 15 (11,20) col 7",
                 pq[1].cyc, pq[1].x, pq[1].y, pq[1].c);
      end
    end
  endtask

  task automatic test_retire_offscreen();
    pa[3] = 1'b0;
    pa[5] = 1'b1; px[5] = 8'd160; py[5] = 7'd50;
    run_pass(645, -10, -10);
    n_checks++;
    if (rq_cyc.size() != 1) begin
      n_fail++; $display("FAIL retire_count: got %0d want 1", rq_cyc.size());
    end else begin
      n_checks++;
      if (rq_cyc[0] != 23 || rq_slot[0] != 5) begin
        n_fail++;
        $display("FAIL retire_event: got cyc %0d slot %0d want cyc 23 slot 5",
                 rq_cyc[0], rq_slot[0]);
      end
    end
    n_checks++;
    if (pq.size() != 1) begin
      n_fail++; $display("FAIL retire_plots: got %0d plots want 1 (slot 3 erase)", pq.size());
    end else begin
      n_checks++;
      if (pq[0].cyc != 14 || pq[0].x !== 8'd11 || pq[0].c !== 3'd0) begin
        n_fail++;
        $display("FAIL retire_erase3: got cyc %0d x %0d col %0d want cyc 14 x 11 col 0",
                 pq[0].cyc, pq[0].x, pq[0].c);
      end
    end
    pa[5] = 1'b0;
    run_pass(645, -10, -10);
    n_checks++;
    if (pq.size() != 0 || rq_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL retire_next_pass: got %0d plots %0d retires want 0 0",
               pq.size(), rq_cyc.size());
    end
  endtask

  task automatic test_wrap_and_ignored_tick();
    pa[159] = 1'b1; px[159] = 8'd255; py[159] = 7'd10;
    run_pass(680, 300, -10);
    n_checks++;
    if (rq_cyc.size() != 1) begin
      n_fail++; $display("FAIL wrap_retire_count: got %0d want 1", rq_cyc.size());
    end else begin
      n_checks++;
      if (rq_cyc[0] != 639 || rq_slot[0] != 159) begin
        n_fail++;
        $display("FAIL wrap_retire_event: got cyc %0d slot %0d want cyc 639 slot 159",
                 rq_cyc[0], rq_slot[0]);
      end
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != 640) begin
      n_fail++;
      $display("FAIL wrap_done: got %0d pulses first %0d want 1 at 640",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
    n_checks++;
    if (busy_cnt != 641 || busy_first != 0 || busy_last != 640) begin
      n_fail++;
      $display("FAIL tick_ignored_busy: got cnt %0d first %0d last %0d want 641 0 640",
               busy_cnt, busy_first, busy_last);
    end
    n_checks++;
    if (pq.size() != 0) begin
      n_fail++; $display("FAIL wrap_no_plot: got %0d plots want 0", pq.size());
    end
    pa[159] = 1'b0;
  endtask

  task automatic test_reset_mid_pass();
    pa[3] = 1'b1; px[3] = 8'd10; py[3] = 7'd20;
    run_pass(645, -10, -10);
    n_checks++;
    if (pq.size() != 1 || pq[0].cyc != 15) begin
      n_fail++; $display("FAIL midrst_setup_draw: got %0d plots want 1 at cycle 15", pq.size());
    end
    run_pass(120, -10, 100);
    n_checks++;
    if (rst_snap !== 38'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h want 0", rst_snap);
    end
    n_checks++;
    if (busy_cnt != 100) begin
      n_fail++; $display("FAIL midrst_abort: got %0d busy cycles want 100", busy_cnt);
    end
    run_pass(645, -10, -10);
    n_checks++;
    if (pq.size() != 1) begin
      n_fail++; $display("FAIL midrst_next_count: got %0d plots want 1 (no erase)", pq.size());
    end else begin
      n_checks++;
      if (pq[0].cyc != 15 || pq[0].c !== 3'd7) begin
        n_fail++;
        $display("FAIL midrst_next_draw: got cyc %0d col %0d want cyc 15 col 7",
                 pq[0].cyc, pq[0].c);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      pa[i] = 1'b0; px[i] = 8'd0; py[i] = 7'd0;
    end
    test_reset();
    test_all_inactive();
    test_first_draw();
    test_erase_redraw();
    test_retire_offscreen();
    test_wrap_and_ignored_tick();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bullet_plotter.md
Name: bullet_plotter

Overview:
- Reader side of the bullet slot pool. Once per frame it scans every bullet slot in order.
- For each slot it erases the pixel drawn there last frame, then draws the slot's current position.
- It retires slots whose bullet has left the screen.
- Sits between the bullet pool's indexed read port and the VGA adapter's pixel-plot interface. It is the only writer of bullet pixels.

Parameters:
- NUM_SLOTS, 160, number of bullet slots scanned per pass
- SLOT_W, 8, width of slot index
- X_MAX, 159, largest on-screen x
- Y_MAX, 119, largest on-screen y
- BG_COLOUR, 3'b000, erase colour
- FG_COLOUR, 3'b111, bullet colour

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse requesting a scan pass
- slot_sel  out  SLOT_W  slot index presented to the pool read port
- slot_active  in  1  slot holds a live bullet; valid the cycle after slot_sel
- slot_x  in  8  slot current x; valid the cycle after slot_sel
- slot_y  in  7  slot current y; valid the cycle after slot_sel
- x  out  8  plot x
- y  out  7  plot y
- colour  out  3  plot colour
- plot  out  1  pixel write strobe; the adapter accepts one pixel every cycle
- retire  out  1  one-cycle pulse: slot retire_slot must be freed
- retire_slot  out  SLOT_W  index being retired
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (resetn low, asynchronous):
  - state IDLE, idx=0.
  - All shadow valid bits cleared.
  - slot_sel=0, x=0, y=0, colour=0, plot=0, retire=0, retire_slot=0, busy=0, done=0.
- Shadow store: per slot prev_x[8], prev_y[7], prev_valid[1]. Records the pixel this block last drew for that slot.
- States: IDLE, ISSUE, WAIT, ERASE, DRAW, DONE.
- IDLE:
  - frame_tick=1 -> ISSUE with idx=0.
  - frame_tick arriving in any other state is ignored; it is not queued.
- Pass timing: cycle 0 is the first ISSUE cycle. Slot k occupies cycles 4k (ISSUE), 4k+1 (WAIT), 4k+2 (ERASE), 4k+3 (DRAW). DONE is at cycle 4*NUM_SLOTS. Timing is fixed regardless of slot contents.
- ISSUE: slot_sel=idx.
- WAIT: slot_sel held. Capture slot_active, slot_x, slot_y at the end of the cycle.
- ERASE:
  - If prev_valid[idx]: plot=1, x=prev_x, y=prev_y, colour=BG_COLOUR.
  - Otherwise plot=0.
- DRAW, with in_bounds = (cap_x <= X_MAX) && (cap_y <= Y_MAX), unsigned compare. Underflow wrap to a large value therefore counts as out of bounds.
  - active && in_bounds: plot=1, x=cap_x, y=cap_y, colour=FG_COLOUR. Shadow <= {cap_x, cap_y, valid=1}.
  - active && !in_bounds: plot=0, retire=1, retire_slot=idx, prev_valid[idx]<=0.
  - !active: plot=0, prev_valid[idx]<=0.
  - Exit: idx==NUM_SLOTS-1 -> DONE; otherwise idx<=idx+1 and -> ISSUE.
- DONE: done=1 for one cycle, idx<=0, -> IDLE.
- busy = (state != IDLE).
- Outputs are decoded from registered state and captured data only. No input-to-output combinational path.
- Erase-then-draw ordering: when an unchanged bullet is erased and redrawn at the same pixel, the final colour is FG_COLOUR.
- Reset mid-pass aborts immediately. The next pass starts from slot 0 with all shadows invalid, so stale pixels are not erased. The top level clears the screen on reset.

Decomposition:
- Shared package bullet_pkg:
  - screen constants X_MAX, Y_MAX
  - BG_COLOUR, FG_COLOUR
  - slot-count constant shared with the bullet pool
  - plotter state encoding
- One sub-module, bullet_shadow_ram:
  - NUM_SLOTS x 15-bit storage for prev_x/prev_y
  - synchronous write, asynchronous read
- prev_valid stays in parent flops so reset can clear it.

Test Plan:
1. Reset, then frame_tick with all slots inactive -> plot never asserted; busy high for exactly 641 cycles; done pulses at cycle 640.
2. Slot 3 active at (10,20), first pass -> single plot at cycle 15: x=10, y=20, colour=7. No erase plot at cycle 14.
3. Second pass with slot 3 at (11,20) -> erase at cycle 14 (10,20,colour 0), then draw at cycle 15 (11,20,colour 7).
4. Slot 5 active at x=160, y=50 -> retire=1 with retire_slot=5 at cycle 23, plot=0. The next pass does no erase for slot 5.
5. Slot 159 active at x=255 (underflow wrap) -> retire at cycle 639, done at cycle 640. frame_tick pulsed at cycle 300 is ignored: no restart, busy stays continuous.
6. resetn low at cycle 100 of a pass with slot 3 drawn -> all outputs 0 immediately. The next pass shows no erase at cycle 14 for slot 3.
